// File: rtl/pedestrian_request_pkg.sv
// Shared definitions for the pedestrian push-button conditioner: FSM state codes,
// counter width and the lamp codes shared with the traffic-light controller.
`timescale 1ns/1ps
package pedestrian_request_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_LOCK = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        LAMP_OFF   = 2'd0,
        LAMP_RED   = 2'd1,
        LAMP_AMBER = 2'd2,
        LAMP_GREEN = 2'd3
    } lamp_e;

endpackage

// File: rtl/pedestrian_request_if.sv
// Button/controller-side signals of the pedestrian request conditioner.
// The slave modport is the conditioner; the master side drives button and ack.
`timescale 1ns/1ps
interface pedestrian_request_if;

    logic bt_raw;
    logic ack;
    logic req;
    logic press_pulse;

    modport master (
        output bt_raw, ack,
        input  req, press_pulse
    );

    modport slave (
        input  bt_raw, ack,
        output req, press_pulse
    );

endinterface

// File: rtl/pedestrian_request_debounce.sv
// Two-flop synchroniser, counter debouncer and rising-edge detector for the raw button.
// A level change is accepted only after DEB_CYCLES consecutive differing samples.
`timescale 1ns/1ps
module bt_debounce
    import pedestrian_request_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic rise_pulse_o
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             db_q, db_d;
    logic             db_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every variable is given a default before the branches so no latch is inferred.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (s2_q != db_q) begin
            if (cnt_q == DEB_LAST) begin
                db_d = s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state flops use non-blocking assignment so all of them sample pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= in_i;
            s2_q     <= s1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            cnt_q    <= cnt_d;
        end
    end

    // Built from flops only, so the pulse is one full cycle wide.
    assign rise_pulse_o = db_q & ~db_dly_q;

endmodule

// File: rtl/pedestrian_request.sv
// Pedestrian request latch: holds one request per debounced press until the controller acks.
// Optional post-ack lockout window is enabled by defining BT_LOCKOUT_EN.
`timescale 1ns/1ps
module pedestrian_request
    import pedestrian_request_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 2
`ifdef BT_LOCKOUT_EN
    , parameter int unsigned LOCKOUT_CYCLES = 4
`endif
) (
    input logic                 clk,
    input logic                 rst,
    pedestrian_request_if.slave bus
);

    logic   press;
    state_e state_q, state_d;
    logic   req_q, req_d;

    bt_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk          (clk),
        .rst          (rst),
        .in_i         (bus.bt_raw),
        .rise_pulse_o (press)
    );

`ifdef BT_LOCKOUT_EN
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

    logic [CNT_W-1:0] lock_q, lock_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lock_q <= '0;
        else      lock_q <= lock_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
`ifdef BT_LOCKOUT_EN
        lock_d  = lock_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_d = ST_PEND;
                    req_d   = 1'b1;
                end
            end
            // Ack has priority: a press landing with it was already served.
            ST_PEND: begin
                if (bus.ack) begin
                    req_d = 1'b0;
`ifdef BT_LOCKOUT_EN
                    state_d = ST_LOCK;
                    lock_d  = LOCK_LAST;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef BT_LOCKOUT_EN
            ST_LOCK: begin
                if (lock_q == '0) state_d = ST_IDLE;
                else              lock_d  = lock_q - CNT_W'(1);
            end
`endif
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    assign bus.req         = req_q;
    assign bus.press_pulse = press;

endmodule

// File: tb/tb_pedestrian_request.sv
// Self-checking bench for pedestrian_request: directed scenarios plus random button/ack
// traffic, compared each cycle against a sample-window reference model.
`timescale 1ns/1ps
module tb_pedestrian_request;

    localparam int DEB = 2;
`ifdef BT_LOCKOUT_EN
    localparam longint LOCK_LEN = 4;
`else
    localparam longint LOCK_LEN = 0;
`endif

    logic clk = 1'b0;
    logic rst;

    pedestrian_request_if bus ();

    pedestrian_request #(
        .DEB_CYCLES (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #1 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    // Reference model: the debounced level flips once the last DEB synchronised samples
    // all differ from it; an accepted press is seen by the latch one edge later.
    longint edge_n  = 0;
    longint lock_end;
    logic   m_db, m_pulse, m_req;
    logic   hist[$];

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b0);
        m_db     = 1'b0;
        m_pulse  = 1'b0;
        m_req    = 1'b0;
        lock_end = -1000;
    endtask

    task automatic model_edge(input logic b, input logic a);
        logic flip;
        logic new_db;
        edge_n++;
        if (m_req) begin
            if (a) begin
                m_req    = 1'b0;
                lock_end = edge_n + LOCK_LEN;
            end
        end else if (m_pulse && edge_n > lock_end) begin
            m_req = 1'b1;
        end
        flip = 1'b1;
        for (int j = 1; j <= DEB; j++) if (hist[j] == m_db) flip = 1'b0;
        new_db  = flip ? ~m_db : m_db;
        m_pulse = new_db & ~m_db;
        m_db    = new_db;
        hist.push_front(b);
        void'(hist.pop_back());
    endtask

    // Drives one clock cycle: inputs set at the falling edge, returns at the next falling edge.
    task automatic cycle(input logic b, input logic a);
        bus.bt_raw = b;
        bus.ack    = a;
        @(posedge clk);
        if (rst) model_edge(b, a);
        @(negedge clk);
        bus.ack = 1'b0;
    endtask

    task automatic test_reset();
        int pulses;
        #0.5;
        checks++;
        if (bus.req !== 1'b0 || bus.press_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: req=%b pulse=%b expected 0 0", bus.req, bus.press_pulse);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0);
            checks++;
            if (bus.req !== 1'b0 || bus.press_pulse !== 1'b0) begin
                errors++;
                $display("FAIL reset_held cyc %0d: req=%b pulse=%b expected 0 0", i, bus.req, bus.press_pulse);
            end
        end
        rst    = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0);
            if (bus.press_pulse === 1'b1) pulses++;
            checks++;
            if (bus.req !== m_req || bus.press_pulse !== m_pulse) begin
                errors++;
                $display("FAIL reset_release cyc %0d: req=%b pulse=%b expected %b %b", i, bus.req, bus.press_pulse, m_req, m_pulse);
            end
        end
        checks++;
        if (pulses != 1 || bus.req !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_summary: pulses=%0d req=%b expected 1 1", pulses, bus.req);
        end
    endtask

    task automatic test_latency();
        logic exp_pulse, exp_req;
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0);
            checks++;
            if (bus.req !== m_req || bus.press_pulse !== m_pulse) begin
                errors++;
                $display("FAIL latency_idle cyc %0d: req=%b pulse=%b expected %b %b", i, bus.req, bus.press_pulse, m_req, m_pulse);
            end
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0);
            exp_pulse = (i == 3);
            exp_req   = (i >= 4);
            checks++;
            if (bus.press_pulse !== exp_pulse || bus.req !== exp_req) begin
                errors++;
                $display("FAIL latency edge k+%0d: req=%b pulse=%b expected %b %b", i, bus.req, bus.press_pulse, exp_req, exp_pulse);
            end
            checks++;
            if (bus.req !== m_req || bus.press_pulse !== m_pulse) begin
                errors++;
                $display("FAIL latency_model edge k+%0d: req=%b pulse=%b expected %b %b", i, bus.req, bus.press_pulse, m_req, m_pulse);
            end
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0);
            checks++;
            if (bus.req !== 1'b1 || bus.press_pulse !== 1'b0) begin
                errors++;
                $display("FAIL latency_hold cyc %0d: req=%b pulse=%b expected 1 0", i, bus.req, bus.press_pulse);
            end
        end
    endtask

    task automatic test_bounce();
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0);
            checks++;
            if (bus.req !== 1'b0 || bus.press_pulse !== 1'b0) begin
                errors++;
                $display("FAIL bounce_single cyc %0d: req=%b pulse=%b expected 0 0", i, bus.req, bus.press_pulse);
            end
        end
        for (int i = 0; i < 12; i++) begin
            cycle(logic'(i % 2 == 0), 1'b0);
            checks++;
            if (bus.req !== 1'b0 || bus.press_pulse !== 1'b0) begin
                errors++;
                $display("FAIL bounce_toggle cyc %0d: req=%b pulse=%b expected 0 0", i, bus.req, bus.press_pulse);
            end
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);
    endtask

    task automatic test_merge();
        for (int i = 0; i < 10; i++) cycle(i < 6, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(i < 6, 1'b0);
            checks++;
            if (bus.req !== 1'b1 || bus.req !== m_req) begin
                errors++;
                $display("FAIL merge_repress cyc %0d: req=%b expected 1 (model %b)", i, bus.req, m_req);
            end
        end
        cycle(1'b0, 1'b1);
        checks++;
        if (bus.req !== 1'b0) begin
            errors++;
            $display("FAIL merge_ack: req=%b expected 0", bus.req);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0);
            checks++;
            if (bus.req !== 1'b0 || bus.req !== m_req) begin
                errors++;
                $display("FAIL merge_after_ack cyc %0d: req=%b expected 0", i, bus.req);
            end
        end
    endtask

    task automatic test_ack_collision();
        logic a;
        logic done = 1'b0;
        for (int i = 0; i < 10; i++) cycle(i < 6, 1'b0);
        for (int i = 0; i < 10; i++) begin
            a = m_pulse && m_req && !done;
            cycle(1'b1, a);
            if (a) begin
                done = 1'b1;
                checks++;
                if (bus.req !== 1'b0) begin
                    errors++;
                    $display("FAIL collision_ack: req=%b expected 0", bus.req);
                end
            end
            checks++;
            if (bus.req !== m_req || bus.press_pulse !== m_pulse) begin
                errors++;
                $display("FAIL collision_model cyc %0d: req=%b pulse=%b expected %b %b", i, bus.req, bus.press_pulse, m_req, m_pulse);
            end
        end
        checks++;
        if (done !== 1'b1 || bus.req !== 1'b0) begin
            errors++;
            $display("FAIL collision_summary: collided=%b req=%b expected 1 0", done, bus.req);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);
    endtask

    task automatic test_lockout();
        logic exp_a;
        for (int i = 0; i < 10; i++) cycle(i < 6, 1'b0);
        // Press accepted two edges after the ack.
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0);
            checks++;
            if (bus.req !== m_req || bus.press_pulse !== m_pulse) begin
                errors++;
                $display("FAIL lockout_early_model cyc %0d: req=%b pulse=%b expected %b %b", i, bus.req, bus.press_pulse, m_req, m_pulse);
            end
        end
        exp_a = (LOCK_LEN == 0);
        checks++;
        if (bus.req !== exp_a) begin
            errors++;
            $display("FAIL lockout_early: req=%b expected %b", bus.req, exp_a);
        end
        for (int i = 0; i < 14; i++) cycle(i >= 4 && i < 10, 1'b0);
        // Press accepted five edges after the ack.
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0);
            checks++;
            if (bus.req !== m_req || bus.press_pulse !== m_pulse) begin
                errors++;
                $display("FAIL lockout_late_model cyc %0d: req=%b pulse=%b expected %b %b", i, bus.req, bus.press_pulse, m_req, m_pulse);
            end
        end
        checks++;
        if (bus.req !== 1'b1) begin
            errors++;
            $display("FAIL lockout_late: req=%b expected 1", bus.req);
        end
    endtask

    task automatic test_reset_mid();
        #0.4 rst = 1'b0;
        #0.1;
        checks++;
        if (bus.req !== 1'b0 || bus.press_pulse !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_pend: req=%b pulse=%b expected 0 0", bus.req, bus.press_pulse);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0);
            checks++;
            if (bus.req !== m_req || bus.press_pulse !== m_pulse) begin
                errors++;
                $display("FAIL reset_fresh_model cyc %0d: req=%b pulse=%b expected %b %b", i, bus.req, bus.press_pulse, m_req, m_pulse);
            end
        end
        checks++;
        if (bus.req !== 1'b1) begin
            errors++;
            $display("FAIL reset_fresh_press: req=%b expected 1", bus.req);
        end
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        #0.4 rst = 1'b0;
        bus.bt_raw = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0);
            checks++;
            if (bus.req !== 1'b0 || bus.press_pulse !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_debounce cyc %0d: req=%b pulse=%b expected 0 0", i, bus.req, bus.press_pulse);
            end
        end
    endtask

    task automatic test_random();
        logic b = 1'b0;
        int   hold = 0;
        logic a;
        for (int i = 0; i < 400; i++) begin
            if (hold == 0) begin
                b    = logic'($urandom_range(0, 1));
                hold = $urandom_range(1, 5);
            end
            hold--;
            a = ($urandom_range(0, 5) == 0);
            cycle(b, a);
            checks++;
            if (bus.req !== m_req || bus.press_pulse !== m_pulse) begin
                errors++;
                $display("FAIL random cyc %0d: req=%b pulse=%b expected %b %b", i, bus.req, bus.press_pulse, m_req, m_pulse);
            end
        end
    endtask

    initial begin
        rst        = 1'b0;
        bus.bt_raw = 1'b1;
        bus.ack    = 1'b0;
        model_reset();
        test_reset();
        test_latency();
        test_bounce();
        test_merge();
        test_ack_collision();
        test_lockout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
